// File: rtl/core_trace_monitor.sv
// core_trace_monitor: run monitor for the ASCA16 core.
// Snoops the fetch bus (pc_in/op_in) and the RAM store bus. Keeps a trace FIFO of
// fetched {pc, op} entries and counts RUN cycles and stores. A run ends on halt
// (the same pc seen HALT_CYCLES more times in a row) or on TIMEOUT RUN cycles.
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   run_en, clear     core running; synchronous clear (same effect as reset)
//   pc_in, op_in      fetch bus
//   st_we/addr/data   RAM store bus
//   rd_en             pop one trace entry; rd_valid/rd_data follow one cycle later
//   trace_count       FIFO occupancy
//   overflow          sticky: an entry was dropped or overwritten
//   halted, timed_out sticky end-of-run flags
//   cycle_count       RUN cycles; store_count: stores seen in RUN
//   last_st_addr/data most recent captured store
//
// Configuration macro CTM_WRAP_EN: when defined, a push into a full FIFO overwrites
// the oldest entry (newest DEPTH fetches kept); otherwise the push is dropped.
module core_trace_monitor #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned HALT_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 76
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       run_en,
    input  logic                       clear,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          op_in,
    input  logic                       st_we,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [ADDR_W+DATA_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic                       overflow,
    output logic                       halted,
    output logic                       timed_out,
    output logic [31:0]                cycle_count,
    output logic [31:0]                store_count,
    output logic [ADDR_W-1:0]          last_st_addr,
    output logic [DATA_W-1:0]          last_st_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = ADDR_W + DATA_W;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
`ifdef CTM_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StTmo} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] prev_pc_q;
    logic              prev_valid_q;
    logic [31:0]       same_q;
    logic [31:0]       cycle_q;
    logic [31:0]       store_q;
    logic [ADDR_W-1:0] st_addr_q;
    logic [DATA_W-1:0] st_data_q;
    logic              halted_q;
    logic              timed_out_q;
    logic              overflow_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              rd_valid_q;
    logic [EntW-1:0]   rd_data_q;
    logic [EntW-1:0]   mem [DEPTH];

    logic        sample;
    logic        same_pc;
    logic        hit_halt;
    logic        hit_tmo;
    logic        push;
    logic        pop;
    logic        full;
    logic        wr_en;
    logic [31:0] cycle_d;

    // The IDLE->RUN edge is itself the first RUN sample.
    always_comb begin
        sample   = run_en && (state_q == StIdle || state_q == StRun);
        same_pc  = prev_valid_q && (pc_in == prev_pc_q);
        cycle_d  = cycle_q + 32'd1;
        hit_halt = sample && same_pc && ((same_q + 32'd1) == HALT_CYCLES);
        hit_tmo  = sample && (cycle_d == TIMEOUT);
        push     = sample && (state_q == StIdle || !same_pc);
        pop      = rd_en && (count_q != '0);
        full     = (count_q == FullCnt);
        wr_en    = !clear && push && (!full || pop || WrapEn);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {pc_in, op_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            same_q       <= '0;
            cycle_q      <= '0;
            store_q      <= '0;
            st_addr_q    <= '0;
            st_data_q    <= '0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else if (clear) begin
            state_q      <= StIdle;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            same_q       <= '0;
            cycle_q      <= '0;
            store_q      <= '0;
            st_addr_q    <= '0;
            st_data_q    <= '0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            if (sample) begin
                cycle_q      <= cycle_d;
                same_q       <= same_pc ? same_q + 32'd1 : 32'd0;
                prev_pc_q    <= pc_in;
                prev_valid_q <= 1'b1;
                if (st_we) begin
                    store_q   <= store_q + 32'd1;
                    st_addr_q <= st_addr;
                    st_data_q <= st_data;
                end
                // Halt takes priority over a coincident timeout.
                if (hit_halt) begin
                    state_q  <= StHalt;
                    halted_q <= 1'b1;
                end else if (hit_tmo) begin
                    state_q     <= StTmo;
                    timed_out_q <= 1'b1;
                end else begin
                    state_q <= StRun;
                end
            end else if (state_q == StRun) begin
                state_q <= StIdle;
            end

            // Trace FIFO pointer/occupancy update.
            if (push && pop) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end else if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
                count_q  <= count_q + CntOne;
            end else if (push) begin
                overflow_q <= 1'b1;
                if (WrapEn) begin
                    wr_ptr_q <= wr_ptr_q + PtrOne;
                    rd_ptr_q <= rd_ptr_q + PtrOne;
                end
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
                count_q  <= count_q - CntOne;
            end

            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign trace_count  = count_q;
    assign overflow     = overflow_q;
    assign halted       = halted_q;
    assign timed_out    = timed_out_q;
    assign cycle_count  = cycle_q;
    assign store_count  = store_q;
    assign last_st_addr = st_addr_q;
    assign last_st_data = st_data_q;

endmodule

// File: tb/tb_core_trace_monitor.sv
// Directed bench for core_trace_monitor with a 4-entry FIFO.
module tb_core_trace_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_en;
    logic        clear;
    logic [15:0] pc_in;
    logic [15:0] op_in;
    logic        st_we;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [2:0]  trace_count;
    logic        overflow;
    logic        halted;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [31:0] store_count;
    logic [15:0] last_st_addr;
    logic [15:0] last_st_data;

    int errors = 0;
    int checks = 0;

    core_trace_monitor #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(4), .HALT_CYCLES(4), .TIMEOUT(76)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .clear(clear),
        .pc_in(pc_in), .op_in(op_in), .st_we(st_we), .st_addr(st_addr),
        .st_data(st_data), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .trace_count(trace_count), .overflow(overflow), .halted(halted),
        .timed_out(timed_out), .cycle_count(cycle_count), .store_count(store_count),
        .last_st_addr(last_st_addr), .last_st_data(last_st_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] p);
        pc_in = p;
        op_in = 16'hA000 + p;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".trace_count"}, 64'(trace_count), 64'd0);
        check({tag, ".flags"}, {61'd0, overflow, halted, timed_out}, 64'd0);
        check({tag, ".rd"}, {31'd0, rd_valid, rd_data}, 64'd0);
        check({tag, ".cycles"}, 64'(cycle_count), 64'd0);
        check({tag, ".stores"}, 64'(store_count), 64'd0);
        check({tag, ".last_st"}, {32'd0, last_st_addr, last_st_data}, 64'd0);
    endtask

    // Pop one entry and check it arrives one cycle later as a single pulse.
    task automatic read_expect(input string tag, input logic [15:0] p);
        logic [31:0] exp;
        exp = {p, 16'hA000 + p};
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'd1);
        check({tag, ".rd_data"}, 64'(rd_data), 64'(exp));
        tick();
        check({tag, ".rd_valid_pulse"}, 64'(rd_valid), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        run_en  = 1'b0;
        clear   = 1'b0;
        st_we   = 1'b0;
        st_addr = '0;
        st_data = '0;
        rd_en   = 1'b0;
        set_pc(16'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_zero("reset");

        // Halt: pc 0,1,2,3 then 3 held.
        run_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pc(16'(i));
            tick();
        end
        check("halt.count4", 64'(trace_count), 64'd4);
        check("halt.cycles4", 64'(cycle_count), 64'd4);
        for (int i = 0; i < 3; i++) tick();
        check("halt.not_yet", 64'(halted), 64'd0);
        tick();
        check("halt.halted", 64'(halted), 64'd1);
        check("halt.timed_out", 64'(timed_out), 64'd0);
        check("halt.cycles", 64'(cycle_count), 64'd8);
        check("halt.overflow", 64'(overflow), 64'd0);
        set_pc(16'd9);
        tick();
        check("halt.no_trace", 64'(trace_count), 64'd4);
        check("halt.no_count", 64'(cycle_count), 64'd8);
        run_en = 1'b0;
        for (int i = 0; i < 4; i++) read_expect("halt.read", 16'(i));
        check("halt.empty", 64'(trace_count), 64'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("halt.empty_rd_valid", 64'(rd_valid), 64'd0);
        check("halt.empty_rd_hold", 64'(rd_data), 64'h0003_A003);

        // Async reset mid-cycle, no clock edge needed.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        reset_n = 1'b1;
        tick();

        // Timeout with pc changing every cycle.
        run_en = 1'b1;
        for (int i = 0; i < 75; i++) begin
            set_pc(16'(i));
            tick();
        end
        check("tmo.before", 64'(timed_out), 64'd0);
        check("tmo.cycles75", 64'(cycle_count), 64'd75);
        set_pc(16'd75);
        tick();
        check("tmo.timed_out", 64'(timed_out), 64'd1);
        check("tmo.halted", 64'(halted), 64'd0);
        check("tmo.cycles", 64'(cycle_count), 64'd76);
        check("tmo.count", 64'(trace_count), 64'd4);
        check("tmo.overflow", 64'(overflow), 64'd1);
        set_pc(16'd200);
        tick();
        check("tmo.stopped", 64'(cycle_count), 64'd76);
        run_en = 1'b0;
`ifdef CTM_WRAP_EN
        read_expect("tmo.read", 16'd72);
`else
        read_expect("tmo.read", 16'd0);
`endif

        // Synchronous clear.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_zero("clear");

        // Overflow with pc 0..5 and no reads.
        run_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_pc(16'(i));
            tick();
        end
        run_en = 1'b0;
        tick();
        check("ovf.count", 64'(trace_count), 64'd4);
        check("ovf.overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
`ifdef CTM_WRAP_EN
            read_expect("ovf.read", 16'(i + 2));
`else
            read_expect("ovf.read", 16'(i));
`endif
        end

        // Store capture.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run_en = 1'b1;
        set_pc(16'd0);
        st_we = 1'b1; st_addr = 16'h0010; st_data = 16'h1234;
        tick();
        set_pc(16'd1);
        st_addr = 16'h0011; st_data = 16'hBEEF;
        tick();
        set_pc(16'd2);
        st_addr = 16'h0012; st_data = 16'h0001;
        tick();
        st_we = 1'b0;
        check("st.count", 64'(store_count), 64'd3);
        check("st.addr", 64'(last_st_addr), 64'h0012);
        check("st.data", 64'(last_st_data), 64'h0001);
        run_en = 1'b0;
        st_we = 1'b1; st_addr = 16'h0013; st_data = 16'hFFFF;
        tick();
        tick();
        st_we = 1'b0;
        check("st.idle_count", 64'(store_count), 64'd3);
        check("st.idle_addr", 64'(last_st_addr), 64'h0012);
        check("st.idle_data", 64'(last_st_data), 64'h0001);

        // Simultaneous push and pop on a full FIFO.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pc(16'(i));
            tick();
        end
        check("pp.full", 64'(trace_count), 64'd4);
        set_pc(16'd4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        run_en = 1'b0;
        check("pp.rd_valid", 64'(rd_valid), 64'd1);
        check("pp.rd_data", 64'(rd_data), 64'h0000_A000);
        check("pp.count", 64'(trace_count), 64'd4);
        check("pp.overflow", 64'(overflow), 64'd0);
        tick();
        for (int i = 1; i < 5; i++) read_expect("pp.read", 16'(i));
        check("pp.empty", 64'(trace_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
